softmax_result_collector: RTL
=============================

# softmax_result_collector

Sink-side companion to the softmax pipeline top. Captures the `number_of_data` results that emerge as `exp_2_data_o` / `exp_2_data_valid_o` pulses, and tracks the argmax while it captures. It then replays the buffered vector to a downstream consumer over a valid/ready handshake. It sits directly after the pipeline top and absorbs its unthrottled output, since the pipeline has no back-pressure.

## Interface
- `data_size`, default 32: word width; IEEE-754 single-precision.
- `number_of_data`, default 10: vector length N; N ≥ 2.
- `index_size`, default `$clog2(number_of_data)`: width of the index/pointer.

Ports:
- `clock_i`, in, 1: single clock; all logic rises on the posedge.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: arm/restart pulse, same cycle as the pipeline's `start_i`.
- `res_data_i`, in, `data_size`: result word; wired to `exp_2_data_o`.
- `res_data_valid_i`, in, 1: result strobe; wired to `exp_2_data_valid_o`.
- `out_data_o`, out, `data_size`: replayed word.
- `out_valid_o`, out, 1: `out_data_o` is valid.
- `out_ready_i`, in, 1: downstream accepts the word.
- `out_last_o`, out, 1: marks word N-1 of the replay.
- `argmax_idx_o`, out, `index_size`: index of the largest result.
- `max_data_o`, out, `data_size`: the largest result word.
- `done_o`, out, 1: one-cycle pulse when the vector is complete.
- `overflow_o`, out, 1: sticky flag; a strobe arrived while not collecting.
- `busy_o`, out, 1: high in COLLECT or DRAIN.

## Operation
- The FSM has three states: IDLE, COLLECT, DRAIN. Reset puts it in IDLE.
- **Reset values:** every output is 0. `wr_ptr` and `rd_ptr` are 0. Buffer contents are don't-care.
- **IDLE:**
  - `start_i` moves to COLLECT.
  - On that move, clear `wr_ptr`, `overflow_o`, `argmax_idx_o`, `max_data_o`, and the first-sample flag.
- **COLLECT:**
  - Each `res_data_valid_i` writes `mem[wr_ptr]` and increments `wr_ptr`.
  - **Argmax, first sample:** the sample always loads `max_data_o` and `argmax_idx_o`.
  - **Argmax, later samples:** load only if `res_data_i[30:0] > max_data_o[30:0]` (unsigned compare, strict). This is valid because softmax outputs are non-negative. Ties keep the lower index. The sign bit is ignored in the compare.
  - A strobe with `wr_ptr == N-1` is the last sample. The FSM then moves to DRAIN with `rd_ptr = 0` and pulses `done_o`.
- **DRAIN:**
  - `out_valid_o = 1` and `out_data_o = mem[rd_ptr]`.
  - `out_last_o = (rd_ptr == N-1)`.
  - A transfer happens when `out_valid_o && out_ready_i`; each transfer increments `rd_ptr`.
  - A transfer with `out_last_o` set returns the FSM to IDLE.
  - `out_data_o` stays stable while `out_ready_i` is low.
- `argmax_idx_o` and `max_data_o` hold from `done_o` until the next `start_i`.
- **Boundary conditions:**
  - **Strobe in IDLE or DRAIN:** the word is dropped, the buffer is untouched, and `overflow_o` is set until the next `start_i`.
  - **`start_i` during COLLECT or DRAIN:** aborts the current vector and re-enters COLLECT with the same clears as above. `out_valid_o` drops the next cycle. No `done_o` pulse for the aborted vector.
  - **`start_i` and `res_data_valid_i` in the same cycle:** `start_i` wins. The strobe is neither stored nor flagged, because the pipeline cannot produce a result of the new vector that early.
  - **Reset mid-operation:** asynchronous return to IDLE with all outputs 0. A partial vector is discarded.
  - Pointers never wrap. `wr_ptr` saturates at the N-1 transition and `rd_ptr` is cleared on exit.

## Timing
- **Capture:** `res_data_valid_i` at edge t, so the word is in `mem` and argmax is updated at t+1.
- **Last sample:** accepted at edge t, so `done_o`, `busy_o` (still high), and `out_valid_o` are all high in cycle t+1.
- **First replay word:** present in the same cycle t+1, so capture-to-first-output latency is 1 cycle.
- **Replay throughput:** 1 word per cycle while `out_ready_i` is high. The minimum drain is N cycles.
- **Output registering:** all outputs are registered except `out_data_o` and `out_last_o`. Those two are combinational from the registered `rd_ptr` and the buffer, with no input-to-output path.
- **`start_i`:** sampled at edge t; `busy_o` is 1 at t+1.

## Structure
- **Shared package `softmax_pkg`:**
  - `DATA_SIZE = 32`.
  - `NUMBER_OF_DATA = 10`.
  - `INDEX_SIZE`.
  - The float magnitude-slice constant `MAG_MSB = 30`.
  - The FSM state encoding, so the bench can decode it.
- **Sub-module `result_buffer`:** an N × `data_size` register array with one write port and one asynchronous read port. There is no reset on the array.
- The FSM, pointers, argmax and flags live in the top of this block.

## Test plan
- **Basic capture and replay:** N=10, `start_i`, then 10 strobes at 2-cycle spacing with `0x3D000000`… and `0x3F000000` at index 6, `out_ready_i` high. Expect `done_o` pulse; `argmax_idx_o = 6`, `max_data_o = 0x3F000000`; 10 words replayed in order; `out_last_o` only on the 10th.
- **Back-pressure:** `out_ready_i` toggled 1-0-0-1 during DRAIN. Expect `out_data_o` stable while ready is low; no word lost or duplicated; IDLE after the 10th transfer.
- **Tie:** indices 2 and 7 both `0x3E800000`, the rest smaller. Expect `argmax_idx_o = 2`.
- **Overflow:** an extra strobe `0x12345678` during DRAIN. Expect `overflow_o = 1`; replay data unchanged; flag cleared by the next `start_i`.
- **Abort:** `start_i` after 4 strobes, then 10 fresh strobes. Expect exactly one `done_o` and a replay of only the fresh vector.
- **Reset:** `reset_n_i` low mid-DRAIN, then high. Expect all outputs 0 immediately (asynchronous), `busy_o = 0`, and no stray `out_valid_o`.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared constants for the softmax result collector: sizes, float magnitude slice
// and the collector FSM state encoding.
package softmax_pkg;

    localparam int DATA_SIZE      = 32;
    localparam int NUMBER_OF_DATA = 10;
    localparam int INDEX_SIZE     = $clog2(NUMBER_OF_DATA);
    localparam int MAG_MSB        = 30;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

endpackage

// File: rtl/result_buffer.sv
// N-entry word store for one softmax vector: one synchronous write port,
// one asynchronous read port, no reset on the array.
module result_buffer #(
    parameter int data_size      = 32,
    parameter int number_of_data = 10,
    parameter int index_size     = $clog2(number_of_data)
) (
    input  logic                  clock_i,
    input  logic                  wr_en_i,
    input  logic [index_size-1:0] wr_addr_i,
    input  logic [data_size-1:0]  wr_data_i,
    input  logic [index_size-1:0] rd_addr_i,
    output logic [data_size-1:0]  rd_data_o
);

    logic [data_size-1:0] mem [number_of_data];

    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/softmax_result_collector.sv
// Captures one softmax result vector from the unthrottled pipeline output, tracks its
// argmax during capture, then replays the vector over a valid/ready handshake.
module softmax_result_collector
    import softmax_pkg::*;
#(
    parameter int data_size      = DATA_SIZE,
    parameter int number_of_data = NUMBER_OF_DATA,
    parameter int index_size     = $clog2(number_of_data)
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic [data_size-1:0]  res_data_i,
    input  logic                  res_data_valid_i,
    output logic [data_size-1:0]  out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic [index_size-1:0] argmax_idx_o,
    output logic [data_size-1:0]  max_data_o,
    output logic                  done_o,
    output logic                  overflow_o,
    output logic                  busy_o
);

    localparam logic [index_size-1:0] LAST_IDX = index_size'(number_of_data - 1);

    // Softmax outputs are non-negative, so an unsigned compare of the magnitude bits
    // orders them correctly; the sign bit is deliberately ignored.
    function automatic logic mag_greater(input logic [data_size-1:0] a,
                                         input logic [data_size-1:0] b);
        return a[MAG_MSB:0] > b[MAG_MSB:0];
    endfunction

    logic [1:0]            state_q, state_d;
    logic [index_size-1:0] wr_ptr_q, wr_ptr_d;
    logic [index_size-1:0] rd_ptr_q, rd_ptr_d;
    logic                  first_q, first_d;
    logic [index_size-1:0] argmax_q, argmax_d;
    logic [data_size-1:0]  max_q, max_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic                  wr_en;
    logic [data_size-1:0]  rd_data;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        first_d    = first_q;
        argmax_d   = argmax_q;
        max_d      = max_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;

        // start_i wins over everything, including a same-cycle strobe.
        if (start_i) begin
            state_d    = ST_COLLECT;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            first_d    = 1'b1;
            argmax_d   = '0;
            max_d      = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (res_data_valid_i) begin
                        wr_en   = 1'b1;
                        first_d = 1'b0;
                        if (first_q || mag_greater(res_data_i, max_q)) begin
                            max_d    = res_data_i;
                            argmax_d = wr_ptr_q;
                        end
                        if (wr_ptr_q == LAST_IDX) begin
                            state_d  = ST_DRAIN;
                            rd_ptr_d = '0;
                            done_d   = 1'b1;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (res_data_valid_i) begin
                        overflow_d = 1'b1;
                    end
                    if (out_ready_i) begin
                        if (rd_ptr_q == LAST_IDX) begin
                            state_d  = ST_IDLE;
                            rd_ptr_d = '0;
                        end else begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    if (res_data_valid_i) begin
                        overflow_d = 1'b1;
                    end
                end
            endcase
        end

        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_DRAIN);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            first_q    <= 1'b0;
            argmax_q   <= '0;
            max_q      <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            first_q    <= first_d;
            argmax_q   <= argmax_d;
            max_q      <= max_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    result_buffer #(
        .data_size      (data_size),
        .number_of_data (number_of_data),
        .index_size     (index_size)
    ) u_buffer (
        .clock_i   (clock_i),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (res_data_i),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    // The buffer has no reset, so the replay port is masked outside DRAIN.
    assign out_data_o   = valid_q ? rd_data : '0;
    assign out_last_o   = valid_q && (rd_ptr_q == LAST_IDX);
    assign out_valid_o  = valid_q;
    assign argmax_idx_o = argmax_q;
    assign max_data_o   = max_q;
    assign done_o       = done_q;
    assign overflow_o   = overflow_q;
    assign busy_o       = busy_q;

endmodule
